// File: rtl/cim_arb_pkg.sv
// Shared types and width helpers for the CIM crossbar arbiter.
// The state enum lives here so its names cannot collide with other global state enums.
package cim_arb_pkg;

  typedef enum logic [1:0] {ARB, GRANT, START, WAIT} arb_state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_XBAR_SIZE = 256;

  function automatic int addr_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  // Wide enough to hold the full burst count, not just burst-1.
  function automatic int cnt_width(input int burst);
    return $clog2(burst + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cim_xbar_arbiter_rr_pick.sv
// Combinational one-hot winner selection from a request vector and a search pointer.
// CIM_ARB_FIXED_PRIO_EN selects lowest-index-wins and ignores ptr.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);

  logic [IW-1:0] j;
  logic          found;

`ifdef CIM_ARB_FIXED_PRIO_EN
  // Scan from the top so the lowest requesting index is the last one written.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    j     = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = IW'(i);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
        found  = 1'b1;
      end
    end
  end
`else
  // Search starts at ptr and wraps at NUM_REQ-1 back to 0.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    j     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = IW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
`endif

endmodule

// File: rtl/cim_xbar_arbiter.sv
// Grants one requester at a time a write burst into the CIM crossbar, then launches and awaits compute.
// Round-robin by default; define CIM_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module cim_xbar_arbiter
  import cim_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int XBAR_SIZE = DEF_XBAR_SIZE,
  parameter int BURST_LEN = XBAR_SIZE,
  localparam int AW = addr_width(XBAR_SIZE),
  localparam int CW = cnt_width(BURST_LEN),
  localparam int IW = idx_width(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ-1:0]          i_we,
  input  logic [NUM_REQ-1:0][AW-1:0]  i_addr,
  output logic [NUM_REQ-1:0]          o_gnt,
  output logic [NUM_REQ-1:0]          o_done,
  output logic                        o_cim_we,
  output logic [AW-1:0]               o_cim_addr,
  output logic                        o_cim_start,
  input  logic                        i_cim_busy,
  output logic                        o_busy
);

  arb_state_t         state;
  logic [IW-1:0]      win;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [CW-1:0]      wcnt;
  logic               first_wait;
  logic               last_wr;
  logic               wait_done;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req (i_req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Only the winner's write port reaches the crossbar, and only while granted.
  assign o_cim_we    = (state == GRANT) && i_we[win];
  assign o_cim_addr  = (state == GRANT) ? i_addr[win] : '0;
  assign o_cim_start = (state == START);
  assign o_busy      = (state != ARB);

  assign last_wr   = o_cim_we && (wcnt == CW'(BURST_LEN - 1));
  assign wait_done = (state == WAIT) && !first_wait && !i_cim_busy;

  always_comb begin
    o_done = '0;
    if (wait_done) o_done[win] = 1'b1;
  end

  // The first WAIT cycle ignores busy so the crossbar has time to raise it after the start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      win        <= '0;
      ptr        <= '0;
      wcnt       <= '0;
      first_wait <= 1'b0;
      o_gnt      <= '0;
    end else begin
      case (state)
        ARB: begin
          if (|i_req && !i_cim_busy) begin
            state <= GRANT;
            win   <= pick_idx;
            o_gnt <= pick_gnt;
            wcnt  <= '0;
          end
        end
        GRANT: begin
          if (o_cim_we) wcnt <= wcnt + CW'(1);
          if (last_wr || !i_req[win]) begin
            state <= START;
            o_gnt <= '0;
          end
        end
        START: begin
          state      <= WAIT;
          first_wait <= 1'b1;
        end
        WAIT: begin
          first_wait <= 1'b0;
          if (wait_done) begin
            state <= ARB;
            wcnt  <= '0;
`ifndef CIM_ARB_FIXED_PRIO_EN
            ptr   <= (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
`endif
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
